// File: rtl/conv_sched_ctrl_if.sv
// Engine-side bundle of the conv layer scheduler: engine reset, completion level
// and the engine's request onto the shared memory port.
interface conv_sched_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);

  logic                  rst_n;
  logic                  done;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  wr_en;

  // The scheduler owns the engine reset and consumes everything else.
  modport master (
    output rst_n,
    input  done,
    input  addr_rd,
    input  addr_wr,
    input  data_wr,
    input  wr_en
  );

  modport slave (
    input  rst_n,
    output done,
    output addr_rd,
    output addr_wr,
    output data_wr,
    output wr_en
  );

endinterface

// File: rtl/conv_sched_ctrl.sv
// Layer scheduler: runs im2col then GEMM per layer, owns both engine resets, muxes the
// shared memory port and supervises each run with a watchdog. Optional: CONV_SCHED_PERF_EN.
module conv_sched_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int RST_HOLD       = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            num_layers,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            layer_idx,
  conv_sched_ctrl_if.master     i2c,
  conv_sched_ctrl_if.master     gemm,
  output logic [ADDR_WIDTH-1:0] mem_addr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr_wr,
  output logic [DATA_WIDTH-1:0] mem_data_wr,
  output logic                  mem_wr_en
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_i2c_cycles,
  output logic [31:0]           perf_gemm_cycles
`endif
);

  localparam int          HOLD_W       = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_I2C_RST,
    S_I2C_RUN,
    S_GEMM_RST,
    S_GEMM_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  logic [3:0]          layers;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [31:0]         wd_cnt;
  logic                run_armed;
  logic                i2c_rst_q;
  logic                gemm_rst_q;

  logic                start_ok;
  logic                in_run;
  logic                eng_done;
  logic                run_done;
  logic                run_timeout;

  assign i2c.rst_n  = i2c_rst_q;
  assign gemm.rst_n = gemm_rst_q;

  // run_armed masks a done level left over from the previous run during the first RUN
  // cycle; a done in the timeout cycle still wins over the watchdog.
  always_comb begin
    start_ok    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    in_run      = (state == S_I2C_RUN) || (state == S_GEMM_RUN);
    eng_done    = (state == S_I2C_RUN) ? i2c.done : gemm.done;
    run_done    = in_run && run_armed && eng_done;
    run_timeout = in_run && (TIMEOUT_CYCLES != 0) && (wd_cnt == TIMEOUT_LAST) && !run_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      layer_idx   <= 4'd0;
      layers      <= 4'd1;
      hold_cnt    <= '0;
      wd_cnt      <= '0;
      run_armed   <= 1'b0;
      i2c_rst_q   <= 1'b0;
      gemm_rst_q  <= 1'b0;
      mem_addr_rd <= '0;
      mem_addr_wr <= '0;
      mem_data_wr <= '0;
      mem_wr_en   <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_ok) begin
            layers     <= (num_layers == 4'd0) ? 4'd1 : num_layers;
            layer_idx  <= 4'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b1;
            hold_cnt   <= '0;
            i2c_rst_q  <= 1'b0;
            gemm_rst_q <= 1'b0;
            state      <= S_I2C_RST;
          end
        end

        S_I2C_RST: begin
          if (hold_cnt == HOLD_LAST) begin
            i2c_rst_q <= 1'b1;
            wd_cnt    <= '0;
            run_armed <= 1'b0;
            state     <= S_I2C_RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_I2C_RUN: begin
          mem_addr_rd <= i2c.addr_rd;
          mem_addr_wr <= i2c.addr_wr;
          mem_data_wr <= i2c.data_wr;
          if (run_done) begin
            i2c_rst_q <= 1'b0;
            hold_cnt  <= '0;
            state     <= S_GEMM_RST;
          end else if (run_timeout) begin
            i2c_rst_q  <= 1'b0;
            gemm_rst_q <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= S_ERR;
          end else begin
            mem_wr_en <= i2c.wr_en & i2c_rst_q;
            run_armed <= 1'b1;
            if (wd_cnt != '1) wd_cnt <= wd_cnt + 32'd1;
          end
        end

        S_GEMM_RST: begin
          if (hold_cnt == HOLD_LAST) begin
            gemm_rst_q <= 1'b1;
            wd_cnt     <= '0;
            run_armed  <= 1'b0;
            state      <= S_GEMM_RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_GEMM_RUN: begin
          mem_addr_rd <= gemm.addr_rd;
          mem_addr_wr <= gemm.addr_wr;
          mem_data_wr <= gemm.data_wr;
          if (run_done) begin
            gemm_rst_q <= 1'b0;
            if (layer_idx + 4'd1 == layers) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              layer_idx <= layer_idx + 4'd1;
              hold_cnt  <= '0;
              state     <= S_I2C_RST;
            end
          end else if (run_timeout) begin
            i2c_rst_q  <= 1'b0;
            gemm_rst_q <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= S_ERR;
          end else begin
            mem_wr_en <= gemm.wr_en & gemm_rst_q;
            run_armed <= 1'b1;
            if (wd_cnt != '1) wd_cnt <= wd_cnt + 32'd1;
          end
        end

        default: begin
          i2c_rst_q  <= 1'b0;
          gemm_rst_q <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_EN
  // Per-engine RUN-cycle totals for one whole run; frozen once the run ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i2c_cycles  <= '0;
      perf_gemm_cycles <= '0;
    end else if (start_ok) begin
      perf_i2c_cycles  <= '0;
      perf_gemm_cycles <= '0;
    end else begin
      if ((state == S_I2C_RUN) && (perf_i2c_cycles != '1))
        perf_i2c_cycles <= perf_i2c_cycles + 32'd1;
      if ((state == S_GEMM_RUN) && (perf_gemm_cycles != '1))
        perf_gemm_cycles <= perf_gemm_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Scoreboard bench for conv_sched_ctrl: stimulus pushes expected engine releases, memory
// writes and run endings; a negedge monitor pops and compares them as the DUT presents them.
module tb_conv_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_layers = 4'd0;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  layer_idx;
  logic [31:0] mem_addr_rd;
  logic [31:0] mem_addr_wr;
  logic [7:0]  mem_data_wr;
  logic        mem_wr_en;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_i2c_cycles;
  logic [31:0] perf_gemm_cycles;
`endif

  int total = 0;
  int bad   = 0;

  logic [6:0]  relQ[$];
  logic [71:0] wrQ[$];
  logic [8:0]  endQ[$];

  logic pI = 1'b0;
  logic pG = 1'b0;
  logic pD = 1'b0;
  logic pE = 1'b0;

  int t2I2c[3]  = '{6, 9, 5};
  int t2Gemm[3] = '{4, 7, 5};

  conv_sched_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) i2c_bus ();
  conv_sched_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) gemm_bus ();

  conv_sched_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(8),
    .RST_HOLD(2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_layers(num_layers),
    .busy(busy),
    .done(done),
    .err(err),
    .layer_idx(layer_idx),
    .i2c(i2c_bus),
    .gemm(gemm_bus),
    .mem_addr_rd(mem_addr_rd),
    .mem_addr_wr(mem_addr_wr),
    .mem_data_wr(mem_data_wr),
    .mem_wr_en(mem_wr_en)
`ifdef CONV_SCHED_PERF_EN
    ,
    .perf_i2c_cycles(perf_i2c_cycles),
    .perf_gemm_cycles(perf_gemm_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Hard stop in case some wait is never satisfied.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time (total=%0d bad=%0d)", total, bad);
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic popRel(input bit eng);
    logic [6:0] act;
    act = eng ? {1'b1, layer_idx, busy, i2c_bus.rst_n} : {1'b0, layer_idx, busy, gemm_bus.rst_n};
    if (relQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL rel_unexpected: got %0h expected no release", act);
    end else begin
      checkOutput("rel_event", 72'(act), 72'(relQ.pop_front()));
    end
  endtask

  task automatic popWr();
    logic [71:0] act;
    act = {mem_addr_rd, mem_addr_wr, mem_data_wr};
    if (wrQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL wr_unexpected: got %0h expected no write", act);
    end else begin
      checkOutput("mem_write", act, wrQ.pop_front());
    end
  endtask

  task automatic popEnd();
    logic [8:0] act;
    act = {err, done, busy, layer_idx, i2c_bus.rst_n, gemm_bus.rst_n};
    if (endQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL end_unexpected: got %0h expected no run end", act);
    end else begin
      checkOutput("run_end", 72'(act), 72'(endQ.pop_front()));
    end
  endtask

  // Monitor: every engine release, memory write and run ending must match the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (i2c_bus.rst_n && !pI) popRel(1'b0);
        if (gemm_bus.rst_n && !pG) popRel(1'b1);
        if (mem_wr_en) popWr();
        if ((done && !pD) || (err && !pE)) popEnd();
      end
      pI = i2c_bus.rst_n;
      pG = gemm_bus.rst_n;
      pD = done;
      pE = err;
    end
  end

  task automatic waitSig(input int which, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = i2c_bus.rst_n;
        1:       hit = gemm_bus.rst_n;
        2:       hit = done;
        default: hit = err;
      endcase
    end
    if (!hit) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: timed out waiting", name);
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_ctrl"},
                72'({busy, done, err, layer_idx, i2c_bus.rst_n, gemm_bus.rst_n, mem_wr_en}), 72'd0);
    checkOutput({name, "_mem"}, {mem_addr_rd, mem_addr_wr, mem_data_wr}, 72'd0);
`ifdef CONV_SCHED_PERF_EN
    checkOutput({name, "_perf"}, 72'({perf_i2c_cycles, perf_gemm_cycles}), 72'd0);
`endif
  endtask

  task automatic checkPerf(input string name, input int i2cCyc, input int gemmCyc);
`ifdef CONV_SCHED_PERF_EN
    checkOutput(name, 72'({perf_i2c_cycles, perf_gemm_cycles}), 72'({32'(i2cCyc), 32'(gemmCyc)}));
`else
    if (name.len() < 0 || i2cCyc < 0 || gemmCyc < 0) $display("[TB] perf args");
`endif
  endtask

  // kind 0: completes normally; 1: watchdog in layer-0 GEMM; 2: aborted by rst in layer-0 GEMM
  task automatic applyStimulus(input logic [3:0] nl, input int kind);
    int eff;
    eff = (nl == 4'd0) ? 1 : int'(nl);
    for (int l = 0; l < ((kind == 0) ? eff : 1); l++) begin
      relQ.push_back({1'b0, 4'(l), 1'b1, 1'b0});
      relQ.push_back({1'b1, 4'(l), 1'b1, 1'b0});
    end
    if (kind == 0) endQ.push_back({1'b0, 1'b1, 1'b0, 4'(eff - 1), 1'b0, 1'b0});
    else if (kind == 1) endQ.push_back({1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    num_layers = nl;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    num_layers = 4'hF;
    @(negedge clk);
    checkOutput("start_accept", 72'({busy, done, err, layer_idx, i2c_bus.rst_n, gemm_bus.rst_n}),
                72'({1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}));
  endtask

  // Follows one engine run: done is sampled by the DUT on the cycles-th RUN edge.
  task automatic runEngine(input bit eng, input int cycles, input bit doWrite,
                           input logic [31:0] ard, input logic [31:0] awr, input logic [7:0] dat,
                           input bit pokeStart);
    waitSig(eng ? 1 : 0, eng ? "gemm_release" : "i2c_release");
    @(posedge clk); #1;
    if (doWrite) begin
      wrQ.push_back({ard, awr, dat});
      if (eng) begin
        gemm_bus.addr_rd = ard; gemm_bus.addr_wr = awr; gemm_bus.data_wr = dat; gemm_bus.wr_en = 1'b1;
      end else begin
        i2c_bus.addr_rd = ard; i2c_bus.addr_wr = awr; i2c_bus.data_wr = dat; i2c_bus.wr_en = 1'b1;
      end
    end
    if (pokeStart) begin
      start      = 1'b1;
      num_layers = 4'd1;
    end
    @(posedge clk); #1;
    if (doWrite) begin
      if (eng) gemm_bus.wr_en = 1'b0;
      else     i2c_bus.wr_en  = 1'b0;
    end
    start      = 1'b0;
    num_layers = 4'hF;
    if (pokeStart) begin
      @(negedge clk);
      checkOutput("start_ignored", 72'({busy, done, layer_idx, i2c_bus.rst_n, gemm_bus.rst_n}),
                  72'({1'b1, 1'b0, 4'd0, 1'b1, 1'b0}));
    end
    repeat (cycles - 3) @(posedge clk);
    #1;
    if (eng) gemm_bus.done = 1'b1;
    else     i2c_bus.done  = 1'b1;
    @(posedge clk); #1;
    if (eng) gemm_bus.done = 1'b0;
    else     i2c_bus.done  = 1'b0;
  endtask

  initial begin
    i2c_bus.done     = 1'b0;
    i2c_bus.wr_en    = 1'b0;
    i2c_bus.addr_rd  = 32'hDEAD_0001;
    i2c_bus.addr_wr  = 32'hDEAD_0002;
    i2c_bus.data_wr  = 8'hD1;
    gemm_bus.done    = 1'b0;
    gemm_bus.wr_en   = 1'b0;
    gemm_bus.addr_rd = 32'hBEEF_0001;
    gemm_bus.addr_wr = 32'hBEEF_0002;
    gemm_bus.data_wr = 8'hB1;

    repeat (3) @(negedge clk);
    checkReset("reset_held");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("reset_released");

    $display("[TB] single layer, im2col 80 / GEMM 50");
    applyStimulus(4'd1, 0);
    runEngine(1'b0, 80, 1'b1, 32'h2000_0000, 32'h1000_0010, 8'hA5, 1'b0);
    runEngine(1'b1, 50, 1'b1, 32'h4000_0008, 32'h3000_0004, 8'h5A, 1'b0);
    waitSig(2, "t1_done");
    repeat (3) @(negedge clk);
    checkOutput("t1_final", 72'({done, busy, err, layer_idx}), 72'({1'b1, 1'b0, 1'b0, 4'd0}));
    checkPerf("t1_perf", 80, 50);

    $display("[TB] three layers from DONE, start poked mid-run, im2col wr_en held in GEMM");
    applyStimulus(4'd3, 0);
    for (int l = 0; l < 3; l++) begin
      runEngine(1'b0, t2I2c[l], 1'b0, 32'd0, 32'd0, 8'd0, l == 0);
      i2c_bus.addr_rd = 32'hBAD0_0000 + 32'(l);
      i2c_bus.addr_wr = 32'hBAD1_0000 + 32'(l);
      i2c_bus.data_wr = 8'hEE;
      i2c_bus.wr_en   = 1'b1;
      runEngine(1'b1, t2Gemm[l], 1'b1, 32'h5000_0000 + 32'(l * 16), 32'h6000_0000 + 32'(l * 16),
                8'h30 + 8'(l), 1'b0);
      i2c_bus.wr_en = 1'b0;
    end
    waitSig(2, "t2_done");
    @(negedge clk);
    checkOutput("t2_final", 72'({done, busy, layer_idx}), 72'({1'b1, 1'b0, 4'd2}));
    checkPerf("t2_perf", 20, 16);

    $display("[TB] stale GEMM done held before its run");
    applyStimulus(4'd1, 0);
    runEngine(1'b0, 4, 1'b0, 32'd0, 32'd0, 8'd0, 1'b0);
    gemm_bus.done = 1'b1;
    waitSig(1, "t3_gemm_release");
    @(negedge clk);
    checkOutput("stale_done_ignored", 72'(done), 72'd0);
    @(negedge clk);
    checkOutput("stale_done_taken", 72'({done, busy}), 72'(2'b10));
    gemm_bus.done = 1'b0;
    checkPerf("t3_perf", 4, 2);

    $display("[TB] watchdog expiry in GEMM");
    applyStimulus(4'd1, 1);
    runEngine(1'b0, 10, 1'b0, 32'd0, 32'd0, 8'd0, 1'b0);
    waitSig(1, "t4_gemm_release");
    repeat (99) @(negedge clk);
    checkOutput("wd_before", 72'({err, busy, gemm_bus.rst_n}), 72'(3'b011));
    @(negedge clk);
    checkOutput("wd_expired",
                72'({err, done, busy, i2c_bus.rst_n, gemm_bus.rst_n, mem_wr_en}), 72'(6'b100000));
    repeat (3) @(negedge clk);
    checkPerf("t4_perf", 10, 100);

    $display("[TB] start from ERR with num_layers=0, rst mid GEMM run");
    applyStimulus(4'd0, 2);
    runEngine(1'b0, 6, 1'b0, 32'd0, 32'd0, 8'd0, 1'b0);
    waitSig(1, "t5_gemm_release");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkReset("midrun_reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkReset("post_reset");

    $display("[TB] fresh two-layer run after reset");
    applyStimulus(4'd2, 0);
    runEngine(1'b0, 5, 1'b0, 32'd0, 32'd0, 8'd0, 1'b0);
    runEngine(1'b1, 4, 1'b1, 32'h7000_0000, 32'h7100_0000, 8'h77, 1'b0);
    runEngine(1'b0, 7, 1'b1, 32'h8000_0000, 32'h8100_0000, 8'h88, 1'b0);
    runEngine(1'b1, 5, 1'b0, 32'd0, 32'd0, 8'd0, 1'b0);
    waitSig(2, "t6_done");
    repeat (3) @(negedge clk);
    checkOutput("t6_final", 72'({done, busy, err, layer_idx}), 72'({1'b1, 1'b0, 1'b0, 4'd1}));
    checkPerf("t6_perf", 12, 9);

    checkOutput("relq_drained", 72'(relQ.size()), 72'd0);
    checkOutput("wrq_drained", 72'(wrQ.size()), 72'd0);
    checkOutput("endq_drained", 72'(endQ.size()), 72'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
